// File: rtl/bin2bcd_pkg.sv
// Shared types and defaults for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DEF_WIDTH  = 16;
  localparam int DEF_DIGITS = 5;

  // Bits needed to count 0..v-1; never less than one bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble correction cell: add 3 to a BCD digit when it is 5 or more.
module bcd_digit_adj (
  input  logic [3:0] i_digit,
  output logic [3:0] o_digit
);

  // 4-bit wrap is harmless: a valid digit 5..9 maps to 8..12.
  always_comb o_digit = (i_digit >= 4'd5) ? (i_digit + 4'd3) : i_digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// Shift-add-3 binary-to-BCD converter: one input bit per clock, registered
// busy/done/bcd outputs, bcd held until the next completed conversion.
module bin2bcd_seq
  import bin2bcd_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int DIGITS = DEF_DIGITS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [WIDTH-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BCDW = 4 * DIGITS;
  localparam int SRW  = WIDTH + BCDW;
  localparam int CW   = clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t            r_state;
  logic [SRW-1:0]    r_sr;
  logic [CW-1:0]     r_cnt;
  logic [BCDW-1:0]   r_bcd;
  logic              r_busy;
  logic              r_done;

  logic [BCDW-1:0]   w_adj;
  logic [SRW-1:0]    w_sr_adj;
  logic [SRW-1:0]    w_shift;

  // Correct every digit of the current BCD field before the shift.
  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .i_digit (r_sr[WIDTH + 4*g +: 4]),
      .o_digit (w_adj[4*g +: 4])
    );
  end

  assign w_sr_adj = {w_adj, r_sr[WIDTH-1:0]};
  assign w_shift  = w_sr_adj << 1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_bcd   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_sr    <= {{BCDW{1'b0}}, bin};
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_sr <= w_shift;
          if (r_cnt == CNT_LAST) begin
            // Only the final shifted BCD field ever reaches the output.
            r_bcd   <= w_shift[SRW-1 -: BCDW];
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign bcd  = r_bcd;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed bench for bin2bcd_seq: latency, boundary values, ignored starts,
// back-to-back throughput, mid-conversion reset and a random sweep.
module tb_bin2bcd_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] bin;
  logic        busy;
  logic        done;
  logic [19:0] bcd;

  int n_cmp;
  int n_err;

  bin2bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Independent decimal model: digit d is (v / 10^d) % 10.
  function automatic logic [19:0] ref_bcd(input int unsigned v);
    logic [19:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Run one conversion from IDLE; inj >= 0 pulses start with bin=1 at that busy cycle.
  task automatic convert(input logic [15:0] v, input logic [19:0] exp,
                         input int inj, input string tag);
    int busy_n;
    bit got;
    @(negedge clk);
    bin   = v;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    bin   = 16'(~v);
    busy_n = 0;
    got    = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      if (done) begin
        got = 1'b1;
      end else begin
        if (busy) busy_n++;
        if (busy_n == inj && inj >= 0) begin
          start = 1'b1;
          bin   = 16'h0001;
        end
        @(posedge clk); #1;
        start = 1'b0;
      end
    end
    chk({tag, "_done_seen"}, 32'(got), 32'd1);
    chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd16);
    chk({tag, "_bcd"}, 32'(bcd), 32'(exp));
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
    @(posedge clk); #1;
    chk({tag, "_done_one_cycle"}, 32'(done), 32'd0);
  endtask

  // Expect no done pulse and no busy for n cycles.
  task automatic quiet(input int n, input string tag);
    int seen;
    seen = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    chk({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    int t_done[3];
    int nd;
    int busy_n;
    logic [15:0] rv;
    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    start = 1'b0;
    bin   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bcd",  32'(bcd),  32'd0);
    @(negedge clk);
    reset = 1'b0;

    convert(16'h0000, 20'h00000, -1, "zero");
    convert(16'h3039, 20'h12345, -1, "d12345");
    convert(16'hFE01, 20'h65025, -1, "d65025");
    convert(16'hFFFF, 20'h65535, -1, "d65535");

    // start during SHIFT is dropped: a single result of 1000 and nothing after.
    convert(16'h03E8, 20'h01000, 5, "ign_start");
    quiet(25, "ign_start");

    // start held high: one done every 18 cycles.
    @(negedge clk);
    bin   = 16'd99;
    start = 1'b1;
    nd = 0;
    for (int c = 0; c < 100 && nd < 3; c++) begin
      @(posedge clk); #1;
      if (done) begin
        t_done[nd] = c;
        nd++;
        chk("b2b_bcd", 32'(bcd), 32'h00099);
      end
    end
    start = 1'b0;
    chk("b2b_count", 32'(nd), 32'd3);
    if (nd == 3) begin
      chk("b2b_gap1", 32'(t_done[1] - t_done[0]), 32'd18);
      chk("b2b_gap2", 32'(t_done[2] - t_done[1]), 32'd18);
    end
    repeat (20) @(posedge clk);

    // Reset during a conversion of 0x1234 aborts it.
    @(negedge clk);
    bin   = 16'h1234;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    busy_n = 0;
    for (int k = 0; k < 7; k++) begin
      if (busy) busy_n++;
      @(posedge clk); #1;
    end
    chk("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_bcd",  32'(bcd),  32'd0);
    chk("abort_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    quiet(25, "abort");
    chk("abort_bcd_held", 32'(bcd), 32'd0);
    convert(16'h1234, 20'h04660, -1, "after_abort");

    // Random sweep against the decimal model.
    for (int i = 0; i < 1000; i++) begin
      rv = 16'($urandom_range(0, 65535));
      convert(rv, ref_bcd(32'(rv)), -1, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
